// File: rtl/systolic_host_loader.sv
// Host-side loader for the systolic wrapper: streams 16 A words and 16 B bytes onto
// the byte bus, starts the array, waits for completion and returns 4 result words.
module systolic_host_loader #(
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_index,
  output logic        r_last,
  output logic [5:0]  m_addr,
  output logic [7:0]  m_wdata,
  output logic        m_write_en,
  output logic        m_read_en,
  output logic        m_start,
  input  logic [7:0]  m_rdata,
  input  logic        m_ready,
  input  logic        m_done,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, READ, OUT, ERR
  } state_t;

  state_t          state, state_d;
  logic [3:0]      word_idx;
  logic [1:0]      byte_idx;
  logic            rd_phase;
  logic [1:0]      pend;
  logic [15:0]     hold;
  logic [31:0]     asm_q;
  logic [TW-1:0]   timer;
  logic            loading;
  logic            accept;
  logic            write_last;

  assign loading    = (state == LOAD_A) || (state == LOAD_B);
  assign accept     = s_valid && s_ready;
  // The final byte of the current word is on the bus this cycle.
  assign write_last = loading && (pend == 2'd1);

  assign r_data  = asm_q;
  assign r_index = word_idx[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    s_ready    = 1'b0;
    m_write_en = 1'b0;
    m_read_en  = 1'b0;
    m_start    = 1'b0;
    r_valid    = 1'b0;
    r_last     = 1'b0;
    busy       = (state != IDLE);
    err        = (state == ERR);
    m_addr     = 6'd0;
    m_wdata    = 8'd0;
    case (state)
      IDLE: begin
        if (m_ready) state_d = LOAD_A;
      end
      LOAD_A: begin
        s_ready    = (pend == 2'd0);
        m_write_en = (pend != 2'd0);
        m_addr     = {1'b0, word_idx, (pend == 2'd1)};
        m_wdata    = (pend == 2'd2) ? hold[7:0] : hold[15:8];
        if (write_last && word_idx == 4'd15) state_d = LOAD_B;
      end
      LOAD_B: begin
        s_ready    = (pend == 2'd0);
        m_write_en = (pend != 2'd0);
        m_addr     = {2'b10, word_idx};
        m_wdata    = hold[7:0];
        if (write_last && word_idx == 4'd15) state_d = START;
      end
      START: begin
        m_start = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (m_done)                   state_d = READ;
        else if (timer >= TIMER_LAST) state_d = ERR;
      end
      READ: begin
        m_read_en = !rd_phase;
        m_addr    = {2'b11, word_idx[1:0], byte_idx};
        if (rd_phase && byte_idx == 2'd3) state_d = OUT;
      end
      OUT: begin
        r_valid = 1'b1;
        r_last  = (word_idx == 4'd3);
        if (r_ready) state_d = (word_idx == 4'd3) ? IDLE : READ;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx <= 4'd0;
      byte_idx <= 2'd0;
      rd_phase <= 1'b0;
      pend     <= 2'd0;
      hold     <= 16'd0;
      asm_q    <= 32'd0;
      timer    <= '0;
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          if (accept) begin
            hold <= s_data;
            pend <= (state == LOAD_A) ? 2'd2 : 2'd1;
          end else if (pend != 2'd0) begin
            pend <= pend - 2'd1;
            if (pend == 2'd1) word_idx <= (word_idx == 4'd15) ? 4'd0 : word_idx + 4'd1;
          end
        end
        START: begin
          timer <= TW'(1);
        end
        WAIT_DONE: begin
          timer <= timer + TW'(1);
          if (m_done) begin
            word_idx <= 4'd0;
            byte_idx <= 2'd0;
            rd_phase <= 1'b0;
          end
        end
        READ: begin
          // Phase 0 issues the read strobe; phase 1 captures the returned byte.
          if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            asm_q[{byte_idx, 3'b000} +: 8] <= m_rdata;
            rd_phase <= 1'b0;
            byte_idx <= (byte_idx == 2'd3) ? 2'd0 : byte_idx + 2'd1;
          end
        end
        OUT: begin
          if (r_ready) word_idx <= (word_idx == 4'd3) ? 4'd0 : word_idx + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
